// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, FSM encoding and widths.
// The arithmetic unit decodes the same OP_* constants.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int RES_W    = 32;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int CNT_W    = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  // Result written back when a divide hits a zero divisor.
  localparam logic [RES_W-1:0] DIV0_RESULT = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 architectural register file: two async read ports, one sync write port.
// r0 reads as zero and is never written; host loads take priority over writeback.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_load_en,
  input  logic [REG_AW-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (i_load_en) begin
      w_we    = 1'b1;
      w_waddr = i_load_addr;
      w_wdata = i_load_data;
    end else if (i_wb_en) begin
      w_we    = 1'b1;
      w_waddr = i_wb_addr;
      w_wdata = i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_we && (w_waddr != '0)) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues register-format instructions to a fixed-latency arithmetic unit and
// writes the result back; owns the register file and the HI register.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_in_opcode,
  input  logic [REG_AW-1:0] i_in_rd,
  input  logic [REG_AW-1:0] i_in_rs1,
  input  logic [REG_AW-1:0] i_in_rs2,
  input  logic              i_load_en,
  input  logic [REG_AW-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic [2:0]        o_alu_operation,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  input  logic [RES_W-1:0]  i_alu_result,
  output logic              o_wb_valid,
  output logic [REG_AW-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [DATA_W-1:0] o_hi_q,
  output logic              o_div_zero_err,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [RES_W-1:0]  r_res;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi;
  logic              r_dz;
  logic [2:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_accept;
  logic              w_div_zero;
  logic              w_wait_done;
  logic              w_load_we;
  logic              w_wb_we;

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_div_zero  = (r_op == OP_DIV) && (w_rd2 == '0);
  assign w_wait_done = (r_cnt == LAT_LAST);
  // Host loads only land while idle, so they never collide with a writeback.
  assign w_load_we   = i_load_en && (r_state == ST_IDLE);
  assign w_wb_we     = (r_state == ST_WB);

  alu_regfile u_regfile (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ra1       (r_rs1),
    .i_ra2       (r_rs2),
    .o_rd1       (w_rd1),
    .o_rd2       (w_rd2),
    .i_load_en   (w_load_we),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .i_wb_en     (w_wb_we),
    .i_wb_addr   (r_rd),
    .i_wb_data   (r_res[DATA_W-1:0])
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = w_div_zero ? ST_WB : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_wait_done) w_state_nxt = ST_WB;
      ST_WB:    w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = 1'b0;
    o_wb_valid = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: o_in_ready = ~i_rst & ~i_load_en;
      ST_WB: begin
        o_wb_valid = 1'b1;
        o_wb_addr  = r_rd;
        o_wb_data  = r_res[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  // ALU-facing registers are loaded leaving READ and cleared on the last WAIT edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_dz     <= 1'b0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op  <= i_in_opcode;
          r_rd  <= i_in_rd;
          r_rs1 <= i_in_rs1;
          r_rs2 <= i_in_rs2;
          r_dz  <= 1'b0;
        end
        ST_READ: if (w_div_zero) begin
          r_dz  <= 1'b1;
          r_res <= DIV0_RESULT;
        end else begin
          r_alu_op <= r_op;
          r_alu_a  <= w_rd1;
          r_alu_b  <= w_rd2;
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_wait_done) begin
            r_res    <= i_alu_result;
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
          end
        end
        ST_WB: if (r_op == OP_MUL) r_hi <= r_res[RES_W-1:DATA_W];
        default: ;
      endcase
    end
  end

  assign o_alu_operation = r_alu_op;
  assign o_alu_op1       = r_alu_a;
  assign o_alu_op2       = r_alu_b;
  assign o_hi_q          = r_hi;
  assign o_div_zero_err  = r_dz;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench: two issue units (ALU latency 1 and 3) share stimulus, each
// fed by its own fixed-latency arithmetic-unit model.
`timescale 1ns/1ps
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, load_en;
  logic [2:0]  in_opcode, in_rd, in_rs1, in_rs2, load_addr;
  logic [15:0] load_data;

  logic        in_ready_1, wb_valid_1, dz_1, busy_1;
  logic [2:0]  alu_operation_1, wb_addr_1;
  logic [15:0] alu_op1_1, alu_op2_1, wb_data_1, hi_1;
  logic [31:0] alu_result_1;

  logic        in_ready_3, wb_valid_3, dz_3, busy_3;
  logic [2:0]  alu_operation_3, wb_addr_3;
  logic [15:0] alu_op1_3, alu_op2_3, wb_data_3, hi_3;
  logic [31:0] alu_result_3;

  alu_issue_unit #(.ALU_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready_1),
    .i_in_opcode(in_opcode), .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_alu_operation(alu_operation_1), .o_alu_op1(alu_op1_1), .o_alu_op2(alu_op2_1),
    .i_alu_result(alu_result_1), .o_wb_valid(wb_valid_1), .o_wb_addr(wb_addr_1),
    .o_wb_data(wb_data_1), .o_hi_q(hi_1), .o_div_zero_err(dz_1), .o_busy(busy_1)
  );

  alu_issue_unit #(.ALU_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready_3),
    .i_in_opcode(in_opcode), .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_alu_operation(alu_operation_3), .o_alu_op1(alu_op1_3), .o_alu_op2(alu_op2_3),
    .i_alu_result(alu_result_3), .o_wb_valid(wb_valid_3), .o_wb_addr(wb_addr_3),
    .o_wb_data(wb_data_3), .o_hi_q(hi_3), .o_div_zero_err(dz_3), .o_busy(busy_3)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD: return {16'h0, 16'(a + b)};
      OP_SUB: return {16'h0, 16'(a - b)};
      OP_MUL: return 32'(a) * 32'(b);
      OP_DIV: return (b == 16'h0) ? 32'hDEAD_BEEF : {16'h0, 16'(a / b)};
      OP_AND: return {16'h0, a & b};
      OP_OR:  return {16'h0, a | b};
      OP_NOT: return {16'h0, ~a};
      default: return {16'h0, a ^ b};
    endcase
  endfunction

  // Arithmetic-unit models: sample on the edge, result valid LATENCY edges later.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always_ff @(posedge clk) p1 <= alu_ref(alu_operation_1, alu_op1_1, alu_op2_1);
  always_ff @(posedge clk) begin
    p3[0] <= alu_ref(alu_operation_3, alu_op1_3, alu_op2_3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_result_1 = p1;
  assign alu_result_3 = p3[2];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready_1 && in_ready_3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'({in_ready_1, in_ready_3}), 32'h3);
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    wait_idle();
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    wait_idle();
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Entered at the negedge of acceptance cycle T+1; k counts cycles after T.
  task automatic watch(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ed,
                       input logic dz);
    int t1 = -1;
    int t3 = -1;
    for (int k = 1; k <= 12; k++) begin
      if (wb_valid_1 && t1 < 0) begin
        t1 = k;
        check({tag, "_wb_data"}, 32'(wb_data_1), 32'(ed));
        check({tag, "_wb_addr"}, 32'(wb_addr_1), 32'(rd));
        check({tag, "_dz_at_wb"}, 32'(dz_1), 32'(dz));
      end
      if (wb_valid_3 && t3 < 0) begin
        t3 = k;
        check({tag, "_wb_data_lat3"}, 32'(wb_data_3), 32'(ed));
      end
      if (dz) begin
        check({tag, "_alu_idle_dz"}, {alu_op1_1, alu_op2_1}, 32'h0);
        check({tag, "_alu_opc_dz"}, 32'(alu_operation_1), 32'h0);
      end else if (k == 2) begin
        check({tag, "_issue_opc"}, 32'(alu_operation_1), 32'(op));
        check({tag, "_issue_ops"}, {alu_op1_1, alu_op2_1}, {ea, eb});
      end else if (k == 3) begin
        check({tag, "_wait_hold"}, {13'h0, alu_operation_1, alu_op1_1}, {13'h0, op, ea});
      end else if (k == 4) begin
        check({tag, "_alu_cleared"}, {alu_op1_1, alu_op2_1}, 32'h0);
      end
      if (t1 >= 0 && t3 >= 0) break;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(t1), dz ? 32'd2 : 32'd4);
    check({tag, "_latency3"}, 32'(t3), dz ? 32'd2 : 32'd6);
  endtask

  typedef struct {
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] ea, eb, ed, ehi;
    logic        edz;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic any_wb;
    vecs[0]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0008, 16'h0000, 1'b0};
    vecs[1]  = '{OP_OR,  3'd6, 3'd3, 3'd0, 16'h0008, 16'h0000, 16'h0008, 16'h0000, 1'b0};
    vecs[2]  = '{OP_SUB, 3'd5, 3'd3, 3'd1, 16'h0008, 16'h0005, 16'h0003, 16'h0000, 1'b0};
    vecs[3]  = '{OP_SUB, 3'd7, 3'd1, 3'd3, 16'h0005, 16'h0008, 16'hFFFD, 16'h0000, 1'b0};
    vecs[4]  = '{OP_AND, 3'd4, 3'd7, 3'd1, 16'hFFFD, 16'h0005, 16'h0005, 16'h0000, 1'b0};
    vecs[5]  = '{OP_NOT, 3'd6, 3'd3, 3'd7, 16'h0008, 16'hFFFD, 16'hFFF7, 16'h0000, 1'b0};
    vecs[6]  = '{OP_DIV, 3'd6, 3'd7, 3'd1, 16'hFFFD, 16'h0005, 16'h3332, 16'h0000, 1'b0};
    vecs[7]  = '{OP_MUL, 3'd4, 3'd1, 3'd2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0};
    vecs[8]  = '{OP_XOR, 3'd5, 3'd4, 3'd6, 16'h3400, 16'h3332, 16'h0732, 16'h0012, 1'b0};
    vecs[9]  = '{OP_DIV, 3'd7, 3'd1, 3'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0012, 1'b1};
    vecs[10] = '{OP_ADD, 3'd0, 3'd5, 3'd4, 16'h0732, 16'h3400, 16'h3B32, 16'h0012, 1'b0};
    vecs[11] = '{OP_OR,  3'd1, 3'd0, 3'd7, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0012, 1'b0};
    vecs[12] = '{OP_DIV, 3'd2, 3'd5, 3'd3, 16'h0732, 16'h0008, 16'h00E6, 16'h0012, 1'b0};

    rst = 1'b1; in_valid = 1'b0; load_en = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'({in_ready_1, in_ready_3}), 32'h0);
    check("rst_ctrl", 32'({wb_valid_1, busy_1, dz_1, busy_3}), 32'h0);
    check("rst_hi_alu", {hi_1, alu_op1_1 | alu_op2_1}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'({in_ready_1, in_ready_3}), 32'h3);

    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);

    for (int i = 0; i < 13; i++) begin
      if (i == 7) begin
        load(3'd1, 16'h1234);
        load(3'd2, 16'h0100);
      end
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      watch($sformatf("v%0d", i), vecs[i].op, vecs[i].rd, vecs[i].ea, vecs[i].eb, vecs[i].ed, vecs[i].edz);
      @(negedge clk);
      check($sformatf("v%0d_hi", i), {hi_1, hi_3}, {vecs[i].ehi, vecs[i].ehi});
      check($sformatf("v%0d_dz_sticky", i), 32'({dz_1, dz_3}), vecs[i].edz ? 32'h3 : 32'h0);
    end

    // Load and instruction offered together: load wins, instruction goes next cycle.
    wait_idle();
    load_en = 1'b1; load_addr = 3'd3; load_data = 16'h00AA;
    in_valid = 1'b1; in_opcode = OP_ADD; in_rd = 3'd2; in_rs1 = 3'd3; in_rs2 = 3'd0;
    #1;
    check("cont_ready_low", 32'({in_ready_1, in_ready_3}), 32'h0);
    @(negedge clk);
    load_en = 1'b0;
    #1;
    check("cont_ready_high", 32'({in_ready_1, in_ready_3}), 32'h3);
    @(negedge clk);
    in_valid = 1'b0;
    watch("cont", OP_ADD, 3'd2, 16'h00AA, 16'h0000, 16'h00AA, 1'b0);

    // Reset while both units are in WAIT aborts the multiply without writeback.
    issue(OP_MUL, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 32'({busy_1, busy_3}), 32'h3);
    rst = 1'b1;
    any_wb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      any_wb = any_wb | wb_valid_1 | wb_valid_3;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'({in_ready_1, in_ready_3}), 32'h3);
    check("abort_hi", {hi_1, hi_3}, 32'h0);
    repeat (8) begin
      any_wb = any_wb | wb_valid_1 | wb_valid_3;
      @(negedge clk);
    end
    check("abort_no_wb", 32'(any_wb), 32'h0);
    issue(OP_OR, 3'd1, 3'd3, 3'd2);
    watch("post_rst", OP_OR, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
